// File: rtl/remote_key_dispatcher.sv
// Key-event dispatcher: suppresses repeated presses inside a hold-off window,
// queues accepted keys in a small FIFO and presents them over a valid/ack handshake.
module remote_key_dispatcher #(
   parameter int DEPTH   = 4,
   parameter int HOLDOFF = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     key_ready,
   input  logic [7:0]               key_in,
   input  logic                     enable,
   input  logic                     evt_ack,
   input  logic                     clear_ovf,
   output logic                     evt_valid,
   output logic [7:0]               evt_key,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(HOLDOFF + 1);

   typedef enum logic {S_IDLE, S_PRESENT} state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      last_key_q, last_key_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [7:0]      evt_key_q, evt_key_d;
   logic            ovf_q, ovf_d;

   logic            intake, suppress, full, push, drop, pop;

   // Full is judged on pre-pop occupancy, so a same-edge pop never rescues a push.
   always_comb begin
      intake   = key_ready & enable;
      suppress = intake && (key_in == last_key_q) && (hold_q != '0);
      full     = (count_q == CW'(DEPTH));
      push     = intake & ~suppress & ~full;
      drop     = intake & ~suppress & full;
   end

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      evt_key_d = evt_key_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (evt_ack) begin
               if (count_q != '0) pop = 1'b1;
               else               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) evt_key_d = mem_q[rd_ptr_q];
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      last_key_d = intake ? key_in : last_key_q;
      hold_d     = hold_q;
      if (intake)             hold_d = HW'(HOLDOFF);
      else if (hold_q != '0)  hold_d = hold_q - HW'(1);
      ovf_d = ovf_q;
      if (drop)           ovf_d = 1'b1;
      else if (clear_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_key_q <= '0;
         hold_q     <= '0;
         evt_key_q  <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         last_key_q <= last_key_d;
         hold_q     <= hold_d;
         evt_key_q  <= evt_key_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage carries no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= key_in;
   end

   assign evt_valid  = (state_q == S_PRESENT);
   assign evt_key    = evt_key_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_remote_key_dispatcher.sv
// Directed bench for remote_key_dispatcher: table of per-cycle vectors plus
// hand-written sequences for hold-off timing, reset and overflow corners.
module tb_remote_key_dispatcher;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_ready, enable, evt_ack, clear_ovf;
   logic [7:0] key_in;
   logic       evt_valid, overflow;
   logic [7:0] evt_key;
   logic [2:0] fifo_count;

   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] got[$];

   always #5 clk = ~clk;

   remote_key_dispatcher #(.DEPTH(4), .HOLDOFF(16)) dut (
      .clk(clk), .reset(reset), .key_ready(key_ready), .key_in(key_in),
      .enable(enable), .evt_ack(evt_ack), .clear_ovf(clear_ovf),
      .evt_valid(evt_valid), .evt_key(evt_key), .fifo_count(fifo_count),
      .overflow(overflow)
   );

   typedef struct {
      logic       kr;
      logic [7:0] key;
      logic       en;
      logic       ack;
      logic       clr;
      logic       ev;
      logic [7:0] ek;
      logic [2:0] cnt;
      logic       ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic kr, input logic [7:0] key, input logic en,
                      input logic ack, input logic clr, input logic ev,
                      input logic [7:0] ek, input logic [2:0] cnt, input logic ovf);
      vec_t v;
      v.kr = kr; v.key = key; v.en = en; v.ack = ack; v.clr = clr;
      v.ev = ev; v.ek = ek; v.cnt = cnt; v.ovf = ovf;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock; records the key accepted on this edge, then settles past the edge.
   task automatic step();
      logic       acc;
      logic [7:0] k;
      acc = evt_valid & evt_ack;
      k   = evt_key;
      @(posedge clk);
      #1;
      if (acc) got.push_back(k);
   endtask

   task automatic idle_inputs();
      key_ready = 0; key_in = 8'h00; evt_ack = 0; clear_ovf = 0; enable = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      #2 reset = 0;
      step();
      step();
      #2 reset = 1;
      step();
   endtask

   initial begin
      idle_inputs();
      reset = 0;
      #2;
      chk("reset evt_valid",  32'(evt_valid),  32'd0);
      chk("reset evt_key",    32'(evt_key),    32'd0);
      chk("reset fifo_count", 32'(fifo_count), 32'd0);
      chk("reset overflow",   32'(overflow),   32'd0);
      @(posedge clk);
      #1 reset = 1;

      // Single key, then ack.
      add(1, 8'h0F, 1, 0, 0,  0, 8'h00, 1, 0);
      add(0, 8'h00, 1, 0, 0,  1, 8'h0F, 0, 0);
      add(0, 8'h00, 1, 0, 0,  1, 8'h0F, 0, 0);
      add(0, 8'h00, 1, 1, 0,  0, 8'h00, 0, 0);
      // Back-to-back delivery with ack held high.
      add(1, 8'h11, 1, 1, 0,  0, 8'h00, 1, 0);
      add(1, 8'h22, 1, 1, 0,  1, 8'h11, 1, 0);
      add(1, 8'h33, 1, 1, 0,  1, 8'h22, 1, 0);
      add(0, 8'h00, 1, 1, 0,  1, 8'h33, 0, 0);
      add(0, 8'h00, 1, 1, 0,  0, 8'h00, 0, 0);
      add(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0);
      // Enable gating.
      add(1, 8'h0F, 0, 0, 0,  0, 8'h00, 0, 0);
      add(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0);
      add(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0);
      add(1, 8'h0F, 1, 0, 0,  0, 8'h00, 1, 0);
      add(0, 8'h00, 1, 0, 0,  1, 8'h0F, 0, 0);
      add(0, 8'h00, 1, 1, 0,  0, 8'h00, 0, 0);
      add(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0);
      // Overflow: six keys three cycles apart, no acks.
      for (int k = 1; k <= 6; k++) begin
         logic [2:0] c;
         c = (k == 1) ? 3'd1 : (k == 6) ? 3'd4 : 3'(k - 1);
         add(1, 8'(k), 1, 0, 0,  (k > 1), 8'h01, c, (k == 6));
         add(0, 8'h00, 1, 0, 0,  1, 8'h01, (k == 1) ? 3'd0 : c, (k == 6));
         add(0, 8'h00, 1, 0, 0,  1, 8'h01, (k == 1) ? 3'd0 : c, (k == 6));
      end
      add(0, 8'h00, 1, 1, 0,  1, 8'h02, 3, 1);
      add(0, 8'h00, 1, 1, 0,  1, 8'h03, 2, 1);
      add(0, 8'h00, 1, 1, 0,  1, 8'h04, 1, 1);
      add(0, 8'h00, 1, 1, 0,  1, 8'h05, 0, 1);
      add(0, 8'h00, 1, 1, 0,  0, 8'h00, 0, 1);
      add(0, 8'h00, 1, 0, 1,  0, 8'h00, 0, 0);
      add(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0);

      foreach (tbl[i]) begin
         key_ready = tbl[i].kr; key_in = tbl[i].key; enable = tbl[i].en;
         evt_ack = tbl[i].ack; clear_ovf = tbl[i].clr;
         step();
         chk($sformatf("row%0d evt_valid", i),  32'(evt_valid),  32'(tbl[i].ev));
         if (tbl[i].ev)
            chk($sformatf("row%0d evt_key", i), 32'(evt_key),    32'(tbl[i].ek));
         chk($sformatf("row%0d fifo_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
         chk($sformatf("row%0d overflow", i),   32'(overflow),   32'(tbl[i].ovf));
      end

      // Repeat suppression: 0F@0, 0F@5 (suppressed), 1E@8, 0F@30.
      do_reset();
      got.delete();
      evt_ack = 1;
      for (int c = 0; c < 40; c++) begin
         key_ready = (c == 0 || c == 5 || c == 8 || c == 30);
         key_in    = (c == 8) ? 8'h1E : 8'h0F;
         step();
      end
      key_ready = 0;
      chk("suppress count", 32'(got.size()), 32'd3);
      if (got.size() == 3) begin
         chk("suppress ev0", 32'(got[0]), 32'h0F);
         chk("suppress ev1", 32'(got[1]), 32'h1E);
         chk("suppress ev2", 32'(got[2]), 32'h0F);
      end
      chk("suppress overflow", 32'(overflow), 32'd0);

      // Window edge: a repeat 16 cycles on is suppressed and restarts the window;
      // a repeat 17 cycles after that is accepted.
      got.delete();
      for (int c = 0; c < 40; c++) begin
         key_ready = (c == 0 || c == 16 || c == 33);
         key_in    = 8'h2A;
         step();
      end
      key_ready = 0;
      chk("window count", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
         chk("window ev0", 32'(got[0]), 32'h2A);
         chk("window ev1", 32'(got[1]), 32'h2A);
      end
      evt_ack = 0;

      // Reset mid-operation with two queued and one presented.
      do_reset();
      key_ready = 1; key_in = 8'h44; step();
      key_in = 8'h55; step();
      key_in = 8'h0F; step();
      key_ready = 0;
      chk("pre-reset valid", 32'(evt_valid),  32'd1);
      chk("pre-reset count", 32'(fifo_count), 32'd2);
      #3 reset = 0;
      #1;
      chk("async reset evt_valid",  32'(evt_valid),  32'd0);
      chk("async reset evt_key",    32'(evt_key),    32'd0);
      chk("async reset fifo_count", 32'(fifo_count), 32'd0);
      chk("async reset overflow",   32'(overflow),   32'd0);
      step();
      #2 reset = 1;
      step();
      key_ready = 1; key_in = 8'h0F; step();
      key_ready = 0;
      chk("post-reset count", 32'(fifo_count), 32'd1);
      step();
      chk("post-reset valid", 32'(evt_valid), 32'd1);
      chk("post-reset key",   32'(evt_key),   32'h0F);
      chk("post-reset count0", 32'(fifo_count), 32'd0);

      // Drop on the same edge as clear_ovf: set wins.
      do_reset();
      key_ready = 1;
      for (int k = 0; k < 5; k++) begin
         key_in = 8'h61 + 8'(k);
         step();
      end
      chk("full count", 32'(fifo_count), 32'd4);
      chk("full no ovf", 32'(overflow), 32'd0);
      key_in = 8'h66; clear_ovf = 1; step();
      key_ready = 0;
      chk("set wins ovf", 32'(overflow), 32'd1);
      chk("set wins count", 32'(fifo_count), 32'd4);
      step();
      chk("clear ovf", 32'(overflow), 32'd0);
      clear_ovf = 0;
      evt_ack = 1;
      got.delete();
      for (int c = 0; c < 8; c++) step();
      chk("drain count", 32'(got.size()), 32'd5);
      if (got.size() == 5) begin
         for (int k = 0; k < 5; k++)
            chk($sformatf("drain ev%0d", k), 32'(got[k]), 32'(8'h61 + 8'(k)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
